// File: rtl/read_instructions.sv
// read_instructions: combinational instruction memory with default program, optional write port under IMEM_WRITE_EN
module read_instructions #(
  parameter int DEPTH = 64,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memAddress,
  output logic [31:0] instruction,
  output logic        misaligned,
  output logic        out_of_range,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data
);
  localparam int IW = $clog2(DEPTH);
  function automatic logic [31:0] dflt(input int i);
    case (i)
      0:       dflt = 32'h0050_0093;
      1:       dflt = 32'h0030_0113;
      2:       dflt = 32'h0020_81B3;
      3:       dflt = 32'h4020_8233;
      4:       dflt = 32'h0020_F2B3;
      5:       dflt = 32'h0020_E333;
      default: dflt = NOP_WORD;
    endcase
  endfunction
  logic [29:0] ridx;
  assign ridx         = memAddress[31:2];
  assign misaligned   = |memAddress[1:0];
  assign out_of_range = ridx >= 30'(DEPTH);
`ifdef IMEM_WRITE_EN
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];
  logic [29:0] widx;
  logic        unused_wr;
  assign widx      = wr_addr[31:2];
  assign unused_wr = ^wr_addr[1:0];
  always_comb begin
    mem_d = mem_q;
    if (wr_en && widx < 30'(DEPTH)) mem_d[widx[IW-1:0]] = wr_data;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < DEPTH; i++) mem_q[i] <= dflt(i);
    else mem_q <= mem_d;
  assign instruction = out_of_range ? NOP_WORD : mem_q[ridx[IW-1:0]];
`else
  logic unused_wr;
  assign unused_wr   = ^{clk, reset, wr_en, wr_addr, wr_data};
  assign instruction = out_of_range ? NOP_WORD : dflt(int'(ridx[IW-1:0]));
`endif
endmodule

// File: tb/tb_read_instructions.sv
// tb_read_instructions: randomized scoreboard bench for read_instructions against an array reference model
module tb_read_instructions;
  localparam int DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_WRITE_EN
  localparam bit WR = 1'b1;
`else
  localparam bit WR = 1'b0;
`endif
  typedef struct {
    logic [31:0] a;
    logic [31:0] ins;
    logic        mis;
    logic        oor;
  } exp_t;
  logic        clk = 1'b0, reset = 1'b0, wr_en = 1'b0;
  logic [31:0] memAddress = '0, wr_addr = '0, wr_data = '0, instruction;
  logic        misaligned, out_of_range;
  int          checks = 0, errors = 0;
  exp_t        q[$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] init_words [6] = '{32'h00500093, 32'h00300113, 32'h002081B3,
                                  32'h40208233, 32'h0020F2B3, 32'h0020E333};
  always #5 clk = ~clk;
  read_instructions #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .reset(reset), .memAddress(memAddress), .instruction(instruction),
    .misaligned(misaligned), .out_of_range(out_of_range),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );
  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = (i < 6) ? init_words[i] : NOP;
  endtask
  task automatic cyc(input logic [31:0] a, input logic we, input logic [31:0] wa,
                     input logic [31:0] wd, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    memAddress = a; wr_en = we; wr_addr = wa; wr_data = wd; reset = rst;
    if (!rst) ref_reset();
    e.a   = a;
    e.ins = ((a >> 2) < DEPTH) ? ref_mem[a >> 2] : NOP;
    e.mis = (a % 4) != 0;
    e.oor = (a >> 2) >= DEPTH;
    q.push_back(e);
    if (WR && rst && we && (wa >> 2) < DEPTH) ref_mem[wa >> 2] = wd;
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (instruction !== e.ins || misaligned !== e.mis || out_of_range !== e.oor) begin
        errors++;
        $display("FAIL read addr=%h got ins=%h mis=%b oor=%b expected ins=%h mis=%b oor=%b",
                 e.a, instruction, misaligned, out_of_range, e.ins, e.mis, e.oor);
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic [31:0] a, wa;
    int r;
    ref_reset();
    cyc(32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(32'd4, 1'b0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(32'(i * 4), 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd6, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd255, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd256, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd252, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'h8000_0000, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'h8000_0008, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd8, 1'b1, 32'd8, 32'hDEADBEEF, 1'b1);
    cyc(32'd8, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd8, 1'b0, 32'd0, 32'd0, 1'b0);
    cyc(32'd8, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd0, 1'b1, 32'd0, 32'h12345678, 1'b0);
    cyc(32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd0, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd12, 1'b1, 32'd256, 32'hCAFEF00D, 1'b1);
    cyc(32'd0, 1'b1, 32'd253, 32'hA5A5A5A5, 1'b1);
    cyc(32'd252, 1'b1, 32'd2, 32'h0BADC0DE, 1'b1);
    cyc(32'd1, 1'b0, 32'd0, 32'd0, 1'b1);
    cyc(32'd252, 1'b0, 32'd0, 32'd0, 1'b1);
    wa = '0;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 11);
      if (r < 4)       a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else if (r < 6)  a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
      else if (r < 8)  a = wa;
      else if (r < 10) a = 32'($urandom_range(DEPTH * 4, 32'hFFFF_FFFF));
      else             a = 32'h8000_0000 | $urandom;
      wa = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) wa = wa | (32'd1 << $urandom_range(8, 31));
      cyc(a, $urandom_range(0, 2) == 0, wa, $urandom, $urandom_range(0, 40) != 0);
    end
    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
